mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mem_access_load_align.sv | 27 ++
 rtl/mem_access.sv | 139 +++++++++++++
 tb/tb_mem_access.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: region codes, IO addresses, funct3 encodings.
package mem_access_pkg;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_DMEM = 2'd1,
    RGN_BIOS = 2'd2,
    RGN_IO   = 2'd3
  } region_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] IO_CYCLE_ADDR   = 32'h8000_0010;
  localparam logic [31:0] IO_INSTRET_ADDR = 32'h8000_0014;
  localparam logic [31:0] IO_CNT_CLR_ADDR = 32'h8000_0018;

  function automatic region_e decode_region(input logic [3:0] top);
    region_e rgn;
    casez (top)
      4'b00?1: rgn = RGN_DMEM;
      4'b0100: rgn = RGN_BIOS;
      4'b1000: rgn = RGN_IO;
      default: rgn = RGN_NONE;
    endcase
    return rgn;
  endfunction

  // funct3[1:0] carries the access width for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load byte/halfword selection with sign or zero extension.
// Purely combinational; no latency, no backpressure.
module load_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_word[{i_offset[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: DMEM/BIOS/IO access decode, store lane steering, load return, cycle/instret counters.
// Load data one cycle after the request edge; stall_i freezes the load stage and holds load_data_o.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DMEM_AW = 14,
  parameter int BIOS_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               mem_valid_i,
  input  logic               mem_we_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        store_data_i,
  input  logic               inst_retire_i,
  output logic               dmem_ena_o,
  output logic [3:0]         dmem_wea_o,
  output logic [DMEM_AW-1:0] dmem_addra_o,
  output logic [31:0]        dmem_dina_o,
  output logic               bios_enb_o,
  output logic [BIOS_AW-1:0] bios_addrb_o,
  input  logic [31:0]        dmem_douta_i,
  input  logic [31:0]        bios_doutb_i,
  output logic [31:0]        load_data_o,
  output logic               load_valid_o,
  output logic               misalign_o
);

  region_e     w_region;
  logic        w_misalign, w_req, w_load, w_store, w_clr;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata, w_io_rdata, w_raw, w_aligned;

  region_e     r_region;
  logic        r_vld, r_misalign, r_held;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_io_data, r_data_hold, r_cycle_cnt, r_instret_cnt;

  assign w_region   = decode_region(addr_i[31:28]);
  assign w_misalign = is_misaligned(funct3_i, addr_i[1:0]);
  // Reset gates the request so enables and write strobes are quiet while rst_n is low.
  assign w_req      = rst_n & mem_valid_i & ~stall_i;
  assign w_load     = w_req & ~mem_we_i & ~w_misalign;
  assign w_store    = w_req &  mem_we_i & ~w_misalign;
  assign w_clr      = w_store & (addr_i == IO_CNT_CLR_ADDR);

  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_mask  = 4'b0001 << addr_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        w_mask  = 4'b0011 << addr_i[1:0];
        w_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
      end
    endcase
  end

  assign dmem_ena_o   = (w_load | w_store) & (w_region == RGN_DMEM);
  assign dmem_wea_o   = (w_store && (w_region == RGN_DMEM)) ? w_mask : 4'b0000;
  assign dmem_addra_o = addr_i[DMEM_AW+1:2];
  assign dmem_dina_o  = w_wdata;
  assign bios_enb_o   = w_load & (w_region == RGN_BIOS);
  assign bios_addrb_o = addr_i[BIOS_AW+1:2];

  assign w_io_rdata = (addr_i == IO_CYCLE_ADDR)   ? r_cycle_cnt   :
                      (addr_i == IO_INSTRET_ADDR) ? r_instret_cnt : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= 1'b0;
      r_misalign <= 1'b0;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_region   <= RGN_NONE;
      r_io_data  <= 32'h0;
    end else if (!stall_i) begin
      r_vld      <= w_load;
      r_misalign <= w_req & w_misalign;
      r_funct3   <= funct3_i;
      r_off      <= addr_i[1:0];
      r_region   <= w_region;
      r_io_data  <= w_io_rdata;
    end
  end

  always_comb begin
    case (r_region)
      RGN_DMEM: w_raw = dmem_douta_i;
      RGN_BIOS: w_raw = bios_doutb_i;
      RGN_IO:   w_raw = r_io_data;
      default:  w_raw = 32'h0;
    endcase
  end

  load_align u_load_align (
    .i_funct3 (r_funct3),
    .i_offset (r_off),
    .i_word   (w_raw),
    .o_data   (w_aligned)
  );

  // The RAM output is not trusted across a stall, so the first stalled cycle snapshots the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held      <= 1'b0;
      r_data_hold <= 32'h0;
    end else begin
      r_held <= stall_i;
      if (!r_held) r_data_hold <= w_aligned;
    end
  end

  assign load_valid_o = r_vld;
  assign load_data_o  = !r_vld ? 32'h0 : (r_held ? r_data_hold : w_aligned);
  assign misalign_o   = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 32'h0;
      r_instret_cnt <= 32'h0;
    end else if (w_clr) begin
      r_cycle_cnt   <= 32'h0;
      r_instret_cnt <= 32'h0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (inst_retire_i) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: loads push expected data, a negedge monitor pops on load_valid_o.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int DAW = 14;
  localparam int BAW = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           stall_i = 1'b0;
  logic           mem_valid_i = 1'b0;
  logic           mem_we_i = 1'b0;
  logic [2:0]     funct3_i = 3'b000;
  logic [31:0]    addr_i = 32'h0;
  logic [31:0]    store_data_i = 32'h0;
  logic           inst_retire_i = 1'b0;
  logic           dmem_ena_o;
  logic [3:0]     dmem_wea_o;
  logic [DAW-1:0] dmem_addra_o;
  logic [31:0]    dmem_dina_o;
  logic           bios_enb_o;
  logic [BAW-1:0] bios_addrb_o;
  logic [31:0]    dmem_douta_i = 32'h0;
  logic [31:0]    bios_doutb_i = 32'h0;
  logic [31:0]    load_data_o;
  logic           load_valid_o;
  logic           misalign_o;

  logic [31:0] dmem [0:(1<<DAW)-1];
  logic [31:0] bios [0:(1<<BAW)-1];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        stall_q = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_exp = 32'h0;

  mem_access #(.DMEM_AW(DAW), .BIOS_AW(BAW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .mem_valid_i   (mem_valid_i),
    .mem_we_i      (mem_we_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .store_data_i  (store_data_i),
    .inst_retire_i (inst_retire_i),
    .dmem_ena_o    (dmem_ena_o),
    .dmem_wea_o    (dmem_wea_o),
    .dmem_addra_o  (dmem_addra_o),
    .dmem_dina_o   (dmem_dina_o),
    .bios_enb_o    (bios_enb_o),
    .bios_addrb_o  (bios_addrb_o),
    .dmem_douta_i  (dmem_douta_i),
    .bios_doutb_i  (bios_doutb_i),
    .load_data_o   (load_data_o),
    .load_valid_o  (load_valid_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM models, read-before-write.
  always @(posedge clk) begin
    if (dmem_ena_o) begin
      dmem_douta_i <= dmem[dmem_addra_o];
      for (int b = 0; b < 4; b++)
        if (dmem_wea_o[b]) dmem[dmem_addra_o][8*b +: 8] <= dmem_dina_o[8*b +: 8];
    end
    if (bios_enb_o) bios_doutb_i <= bios[bios_addrb_o];
    stall_q <= stall_i;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 1'b0;
    end else if (stall_q) begin
      if (have_last) begin
        check("hold_valid", 32'(load_valid_o), 32'd1);
        check("hold_data", load_data_o, last_exp);
      end
    end else begin
      have_last = 1'b0;
      if (load_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load_valid", 32'(load_valid_o), 32'd0);
        end else begin
          last_exp  = exp_q.pop_front();
          have_last = 1'b1;
          check(name_q.pop_front(), load_data_o, last_exp);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic ret);
    @(negedge clk);
    mem_valid_i   = 1'b1;
    mem_we_i      = we;
    funct3_i      = f3;
    addr_i        = a;
    store_data_i  = d;
    inst_retire_i = ret;
    #1;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                      input string nm);
    issue(1'b0, f3, a, 32'h0, 1'b0);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mem_valid_i = 1'b0;
      mem_we_i    = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<DAW); i++) dmem[i] = 32'h0;
    for (int i = 0; i < (1<<BAW); i++) bios[i] = 32'h0;
    bios[2] = 32'hDEAD_BEEF;

    // A store presented during reset must not reach the RAM.
    mem_valid_i = 1'b1; mem_we_i = 1'b1; funct3_i = F3_W;
    addr_i = 32'h1000_0000; store_data_i = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dmem_ena", 32'(dmem_ena_o), 32'd0);
    check("rst_dmem_wea", 32'(dmem_wea_o), 32'd0);
    check("rst_bios_enb", 32'(bios_enb_o), 32'd0);
    check("rst_load_valid", 32'(load_valid_o), 32'd0);
    check("rst_load_data", load_data_o, 32'h0);
    check("rst_misalign", 32'(misalign_o), 32'd0);

    @(negedge clk);
    mem_valid_i = 1'b0; mem_we_i = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    load(F3_W, 32'h8000_0010, 32'd5, "cycle_cnt_5");
    check("io_no_dmem_ena", 32'(dmem_ena_o), 32'd0);
    load(F3_W, 32'h8000_0014, 32'd0, "instret_zero");
    idle(1);
    inst_retire_i = 1'b1;
    idle(2);
    load(F3_W, 32'h8000_0014, 32'd3, "instret_3");
    issue(1'b1, F3_W, 32'h8000_0018, 32'h0, 1'b1);
    check("clr_no_dmem_ena", 32'(dmem_ena_o), 32'd0);
    load(F3_W, 32'h8000_0014, 32'd0, "instret_after_clr");
    load(F3_W, 32'h8000_0010, 32'd1, "cycle_after_clr");

    issue(1'b1, F3_W, 32'h1000_0000, 32'h0000_8000, 1'b0);
    check("sw_ena", 32'(dmem_ena_o), 32'd1);
    check("sw_wea", 32'(dmem_wea_o), 32'hF);
    check("sw_dina", dmem_dina_o, 32'h0000_8000);
    check("sw_addra", 32'(dmem_addra_o), 32'd0);
    issue(1'b1, F3_B, 32'h1000_0003, 32'h0000_00A5, 1'b0);
    check("sb_wea", 32'(dmem_wea_o), 32'h8);
    check("sb_dina", dmem_dina_o, 32'hA5A5_A5A5);
    issue(1'b1, F3_H, 32'h1000_0006, 32'h0000_1234, 1'b0);
    check("sh_wea", 32'(dmem_wea_o), 32'hC);
    check("sh_dina", dmem_dina_o, 32'h1234_1234);
    check("sh_addra", 32'(dmem_addra_o), 32'd1);

    load(F3_B,  32'h1000_0001, 32'hFFFF_FF80, "lb_neg");
    load(F3_BU, 32'h1000_0001, 32'h0000_0080, "lbu");
    load(F3_B,  32'h1000_0003, 32'hFFFF_FFA5, "lb_b3");
    load(F3_H,  32'h1000_0000, 32'hFFFF_8000, "lh");
    load(F3_HU, 32'h1000_0002, 32'h0000_A500, "lhu_hi");
    load(F3_W,  32'h1000_0004, 32'h1234_0000, "lw_w1");
    load(F3_W,  32'h3000_0000, 32'hA500_8000, "lw_alias");

    issue(1'b0, F3_W, 32'h1000_0002, 32'h0, 1'b0);
    check("lw_mis_ena", 32'(dmem_ena_o), 32'd0);
    idle(1);
    check("lw_mis_pulse", 32'(misalign_o), 32'd1);
    check("lw_mis_no_valid", 32'(load_valid_o), 32'd0);
    idle(1);
    check("lw_mis_end", 32'(misalign_o), 32'd0);
    issue(1'b1, F3_H, 32'h1000_0001, 32'h0000_FFFF, 1'b0);
    check("sh_mis_ena", 32'(dmem_ena_o), 32'd0);
    check("sh_mis_wea", 32'(dmem_wea_o), 32'd0);
    idle(1);
    check("sh_mis_pulse", 32'(misalign_o), 32'd1);
    idle(1);

    load(F3_W, 32'h4000_0008, 32'hDEAD_BEEF, "bios_lw");
    check("bios_enb", 32'(bios_enb_o), 32'd1);
    check("bios_addrb", 32'(bios_addrb_o), 32'd2);
    check("bios_no_dmem", 32'(dmem_ena_o), 32'd0);
    load(F3_HU, 32'h4000_000A, 32'h0000_DEAD, "bios_lhu");
    issue(1'b1, F3_W, 32'h4000_0008, 32'h1111_1111, 1'b0);
    check("bios_sw_enb", 32'(bios_enb_o), 32'd0);
    check("bios_sw_dmem", 32'(dmem_ena_o), 32'd0);
    load(F3_W, 32'h5000_0000, 32'h0, "unmapped_lw");
    check("unmapped_enb", 32'(bios_enb_o | dmem_ena_o), 32'd0);

    load(F3_W, 32'h1000_0000, 32'hA500_8000, "pre_stall");
    @(negedge clk);
    stall_i = 1'b1; mem_valid_i = 1'b1; mem_we_i = 1'b0;
    funct3_i = F3_W; addr_i = 32'h1000_0004;
    #1;
    check("stall_no_ena", 32'(dmem_ena_o), 32'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    stall_i = 1'b0; mem_valid_i = 1'b0;
    idle(2);

    // Reset lands right after the capture edge of a DMEM load.
    issue(1'b0, F3_W, 32'h1000_0000, 32'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(load_valid_o), 32'd0);
    check("rst_mid_data", load_data_o, 32'h0);
    check("rst_mid_ena", 32'(dmem_ena_o), 32'd0);
    @(negedge clk);
    mem_valid_i = 1'b0;
    rst_n = 1'b1;
    idle(3);
    check("post_rst_no_valid", 32'(load_valid_o), 32'd0);
    load(F3_W, 32'h1000_0000, 32'hA500_8000, "post_rst_lw");
    idle(3);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
